// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference if it fits.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] rem_in,
    input  logic         dbit,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_out,
    output logic         qbit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in W+1 bits and bit W of the difference is the borrow.
    always_comb begin
        shifted = {rem_in, dbit};
        diff    = shifted - {1'b0, dvs};
        qbit    = ~diff[W];
        rem_out = qbit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential W-cycle signed/unsigned divider: one quotient bit per clock,
// MSB first, with sign correction applied as the final bit is produced.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_op,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);

    div_state_e   state;
    logic [CW-1:0] cnt;
    logic [W-1:0] rem_r;
    logic [W-1:0] quo_r;
    logic [W-1:0] dvs_r;
    logic         neg_q;
    logic         neg_r;
    logic         zero_r;

    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [W-1:0] rem_nxt;
    logic         qbit;
    logic [W-1:0] q_fin;

    assign a_mag = (signed_op && dividend[W-1]) ? -dividend : dividend;
    assign b_mag = (signed_op && divisor[W-1])  ? -divisor  : divisor;

    // quo_r doubles as the dividend shifter: its MSB feeds the step while
    // quotient bits enter at the bottom.
    div_step #(.W(W)) u_step (
        .rem_in  (rem_r),
        .dbit    (quo_r[W-1]),
        .dvs     (dvs_r),
        .rem_out (rem_nxt),
        .qbit    (qbit)
    );

    assign q_fin = {quo_r[W-2:0], qbit};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (zero_r) begin
                        // Zero divisor: no iterations, report the fixed result.
                        quotient    <= '1;
                        remainder   <= rem_r;
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rem_r <= rem_nxt;
                        quo_r <= q_fin;
                        cnt   <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            quotient  <= neg_q ? -q_fin : q_fin;
                            remainder <= neg_r ? -rem_nxt : rem_nxt;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= RUN;
                        neg_q       <= signed_op & (dividend[W-1] ^ divisor[W-1]);
                        neg_r       <= signed_op & dividend[W-1];
                        if (divisor == '0) begin
                            zero_r <= 1'b1;
                            rem_r  <= dividend;
                            quo_r  <= '0;
                            dvs_r  <= '0;
                            cnt    <= '0;
                        end else begin
                            zero_r <= 1'b0;
                            rem_r  <= '0;
                            quo_r  <= a_mag;
                            dvs_r  <= b_mag;
                            cnt    <= CW'(W);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider against a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_z;

    seq_divider #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: SV integer division truncates toward zero and % follows the
    // dividend's sign; 64-bit math makes the most-negative / -1 case wrap cleanly.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa;
        longint sb;
        z = (b == 0);
        if (z) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Starts a division at the next edge and waits for done; inj pulses a
    // second start with fresh operands ten cycles into the run.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit inj);
        int lat;
        ref_div(a, b, s, exp_q, exp_r, exp_z);
        start = 1'b1; dividend = a; divisor = b; signed_op = s;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom_range(0, 1));
        check("busy_run", busy, 1);
        check("dbz_clr", div_by_zero, 0);
        lat = 0;
        while (!done && lat < W + 8) begin
            start = inj && (lat == 10);
            if (start) begin
                dividend = $urandom;
                divisor  = $urandom_range(1, 9);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, (b == 0) ? 1 : W);
        check("quotient", quotient, exp_q);
        check("remainder", remainder, exp_r);
        check("div_by_zero", div_by_zero, exp_z);
        check("busy_done", busy, 0);
    endtask

    task automatic hold_chk();
        @(negedge clk);
        check("done_pulse", done, 0);
        check("q_hold", quotient, exp_q);
        check("r_hold", remainder, exp_r);
        check("dbz_hold", div_by_zero, exp_z);
    endtask

    task automatic zero_chk(input string tag);
        check({tag, "_q"}, quotient, 0);
        check({tag, "_r"}, remainder, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_dbz"}, div_by_zero, 0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        zero_chk("rst");
        reset = 1'b0;

        do_div(32'd100, 32'd7, 1'b0, 1'b0);                hold_chk();
        do_div(32'hFFFFFF9C, 32'd7, 1'b1, 1'b0);           hold_chk();
        do_div(32'd100, 32'hFFFFFFF9, 1'b1, 1'b0);         hold_chk();
        do_div(32'h1234, 32'd0, 1'b0, 1'b0);               hold_chk();
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);    hold_chk();
        do_div(32'hFFFFFF9C, 32'd7, 1'b0, 1'b0);           hold_chk();
        do_div(32'd1234567, 32'd89, 1'b0, 1'b1);           hold_chk();

        // Back-to-back: the second start lands in the DONE cycle of the first.
        do_div(32'd500, 32'd3, 1'b0, 1'b0);
        do_div(32'hFFFFF000, 32'd16, 1'b1, 1'b0);          hold_chk();

        // Reset in the middle of a run.
        start = 1'b1; dividend = 32'd777; divisor = 32'd5; signed_op = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        zero_chk("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        do_div(32'd9, 32'd3, 1'b0, 1'b0);                  hold_chk();

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 20));
                2:       b = -W'($urandom_range(1, 20));
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (i % 5 == 0) a = -W'($urandom_range(0, 1000));
            do_div(a, b, s, 1'($urandom_range(0, 1)));
            if (i % 2 == 1) hold_chk();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
